// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU engine for the execute stage.
// The {hi,lo} result is held in DONE until the writeback side acks or the op is flushed.
module muldiv_unit #(
    parameter int unsigned MUL_CYCLES = 2,
    parameter logic [31:0] DIV0_Q     = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        ack,
    output logic        busy,
    output logic        valid,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LAST = 6'd31;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        sgn_q, sgn_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        src_a_neg;
    logic [31:0] src_a_mag;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] prod_mag;
    logic [63:0] prod;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] rem_step;
    logic [31:0] quo_step;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // Signed ops work on magnitudes; the sign is put back at the end.
    always_comb begin
        src_a_neg = ~op[0] & src_a[31];
        src_a_mag = src_a_neg ? (32'd0 - src_a) : src_a;
        a_neg     = sgn_q & a_q[31];
        b_neg     = sgn_q & b_q[31];
        a_mag     = a_neg ? (32'd0 - a_q) : a_q;
        b_mag     = b_neg ? (32'd0 - b_q) : b_q;
        prod_mag  = {32'd0, a_mag} * {32'd0, b_mag};
        prod      = (a_neg ^ b_neg) ? (64'd0 - prod_mag) : prod_mag;
    end

    // One restoring step: quotient register doubles as the dividend shifter.
    always_comb begin
        div_shift = {rem_q, quo_q[31]};
        div_ge    = div_shift >= {1'b0, b_mag};
        rem_step  = div_ge ? (div_shift[31:0] - b_mag) : div_shift[31:0];
        quo_step  = {quo_q[30:0], div_ge};
        q_fix     = (a_neg ^ b_neg) ? (32'd0 - quo_q) : quo_q;
        r_fix     = a_neg ? (32'd0 - rem_q) : rem_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    state_d = op[1] ? S_DIV : S_MUL;
                    cnt_d   = 6'd0;
                    sgn_d   = ~op[0];
                    a_d     = src_a;
                    b_d     = src_b;
                    rem_d   = 32'd0;
                    quo_d   = src_a_mag;
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == MUL_LAST) begin
                    state_d = S_DONE;
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    if (cnt_q == DIV_LAST) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    if (b_q == 32'd0) begin
                        hi_d = a_q;
                        lo_d = DIV0_Q;
                    end else begin
                        hi_d = r_fix;
                        lo_d = q_fix;
                    end
                end
            end
            S_DONE: begin
                if (flush || ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            sgn_q   <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign valid = (state_q == S_DONE);
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed spec vectors plus randomized traffic for muldiv_unit,
// checked every cycle against a transaction-level model of the engine.
module tb_muldiv_unit;

    localparam int MULC = 2;
    localparam logic [31:0] DIV0 = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        ack;
    logic        busy;
    logic        valid;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.MUL_CYCLES(MULC), .DIV0_Q(DIV0)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush), .ack(ack),
        .busy(busy), .valid(valid), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", nm, act, exp);
        end
    endtask

    // Architectural result {hi,lo} from plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint p;
        int sa;
        int sb;
        int q;
        int r;
        case (o)
            2'b00: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return 64'(p);
            end
            2'b01: return {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) return {a, DIV0};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sa = $signed(a);
                sb = $signed(b);
                q = sa / sb;
                r = sa % sb;
                return {32'(r), 32'(q)};
            end
            default: begin
                if (b == 32'd0) return {a, DIV0};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Transaction-level model: one op in flight, a countdown to its result.
    bit          m_busy = 1'b0;
    bit          m_valid = 1'b0;
    int          m_left = 0;
    logic [63:0] m_pend = 64'd0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b0;
            m_valid = 1'b0;
            m_hi = 32'd0;
            m_lo = 32'd0;
        end else if (!m_busy) begin
            if (start && !flush) begin
                m_busy = 1'b1;
                m_pend = ref_result(op, src_a, src_b);
                m_left = (op[1] ? 34 : 1 + MULC) - 1;
            end
        end else if (flush) begin
            m_busy = 1'b0;
            m_valid = 1'b0;
        end else if (m_valid) begin
            if (ack) begin
                m_busy = 1'b0;
                m_valid = 1'b0;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_valid = 1'b1;
                m_hi = m_pend[63:32];
                m_lo = m_pend[31:0];
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(m_busy));
        chk("valid", 64'(valid), 64'(m_valid));
        chk("hi", 64'(hi), 64'(m_hi));
        chk("lo", 64'(lo), 64'(m_lo));
    end

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            4: return 32'd0 - 32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called just after a negedge; that cycle is T.
    task automatic run_op(input string nm, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat,
                          input int hold, input bit pulse);
        int n;
        start = 1'b1;
        op = o;
        src_a = a;
        src_b = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start = 1'b0;
                src_a = $urandom;
                src_b = $urandom;
            end
        end while (!valid && n < 60);
        chk({nm, "_latency"}, 64'(n), 64'(lat));
        chk({nm, "_result"}, {hi, lo}, exp);
        for (int i = 0; i < hold; i++) begin
            start = pulse;
            op = 2'($urandom);
            @(negedge clk);
            start = 1'b0;
            chk({nm, "_hold"}, {31'd0, valid, hi, lo}, {31'd0, 1'b1, exp});
        end
        ack = 1'b1;
        start = pulse;
        @(negedge clk);
        ack = 1'b0;
        start = 1'b0;
        chk({nm, "_release"}, {62'd0, busy, valid}, 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        op = 2'b10;
        src_a = 32'd100;
        src_b = 32'd3;
        flush = 1'b0;
        ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", {30'd0, busy, valid, hi, lo}, 64'd0);

        chk("pin_mult", ref_result(2'b00, 32'hFFFF_FFFE, 32'd3), 64'hFFFF_FFFF_FFFF_FFFA);
        chk("pin_multu", ref_result(2'b01, 32'hFFFF_FFFE, 32'd3), 64'h0000_0002_FFFF_FFFA);
        chk("pin_div", ref_result(2'b10, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("pin_divu", ref_result(2'b11, 32'd7, 32'd2), 64'h0000_0001_0000_0003);
        chk("pin_div0", ref_result(2'b11, 32'h1234, 32'd0), 64'h0000_1234_FFFF_FFFF);
        chk("pin_ovf", ref_result(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

        run_op("mult", 2'b00, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 3, 0, 1'b0);
        run_op("multu", 2'b01, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA, 3, 1, 1'b0);
        run_op("div", 2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34, 0, 1'b0);
        run_op("divu", 2'b11, 32'd7, 32'd2, 64'h0000_0001_0000_0003, 34, 2, 1'b0);
        run_op("div0", 2'b11, 32'h1234, 32'd0, 64'h0000_1234_FFFF_FFFF, 34, 0, 1'b0);
        run_op("ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 34, 0, 1'b0);

        start = 1'b1;
        op = 2'b10;
        src_a = 32'd1000;
        src_b = 32'd7;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            chk("flush_inflight", 64'(busy), 64'd1);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle", {30'd0, busy, valid, hi, lo}, 64'h0000_0000_8000_0000);
        run_op("restart", 2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 34, 0, 1'b0);

        run_op("hold", 2'b00, 32'd12345, 32'hFFFF_FF00, ref_result(2'b00, 32'd12345, 32'hFFFF_FF00),
               3, 5, 1'b1);

        repeat (6000) begin
            @(negedge clk);
            reset = ($urandom_range(0, 999) == 0);
            start = ($urandom_range(0, 3) == 0);
            op = 2'($urandom);
            src_a = rnd_val();
            src_b = rnd_val();
            flush = ($urandom_range(0, 49) == 0);
            ack = ($urandom_range(0, 2) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        ack = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
